// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: 68000 bus-cycle terminator generating DTACK_n/VPA_n/BERR_n
// with per-channel wait states, external DTACK, IACK handling and a bus-error watchdog.
module bus_cycle_controller #(
  parameter int NUM_CS = 4,
  parameter int WAIT_W = 4,
  parameter logic [NUM_CS*WAIT_W-1:0] WAIT_STATES = '0,
  parameter logic [NUM_CS-1:0] EXT_MASK = '0,
  parameter logic [6:0] AUTOVEC_MASK = 7'h7F,
  parameter int TO_W = 8,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              AS_n,
  input  logic [2:0]        FC,
  input  logic [2:0]        ADDR_L,
  input  logic [NUM_CS-1:0] CS_n,
  input  logic [NUM_CS-1:0] DTACK_EXT_n,
  input  logic              DTACK_VEC_n,
  input  logic              CNT_CLR,
  output logic              DTACK_n,
  output logic              VPA_n,
  output logic              BERR_n,
  output logic              BUSY,
  output logic [7:0]        BERR_CNT
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_ACK = 3'd2, S_VPA = 3'd3, S_BERR = 3'd4;
  localparam logic [1:0] M_NONE = 2'd0, M_INT = 2'd1, M_EXT = 2'd2, M_VEC = 2'd3;
  localparam logic [7:0] AV = {AUTOVEC_MASK, 1'b0};
  localparam logic [TO_W-1:0] TO = TO_W'(BERR_TIMEOUT);
  logic [2:0] state, nxt;
  logic [1:0] mode, mode_n;
  logic [NUM_CS-1:0] sel, sel_n, cs;
  logic [WAIT_W-1:0] wcnt, wcnt_n, wdec, wfield;
  logic [TO_W-1:0] wd, wd_n, wd_inc;
  logic multi, is_ext, ext_ok, zero, term;
  assign cs = ~CS_n;
  assign multi = |(cs & (cs - NUM_CS'(1)));
  assign is_ext = |(cs & EXT_MASK);
  assign wdec = wcnt == '0 ? '0 : wcnt - WAIT_W'(1);
  // zero means the wait count expires on this edge, so W wait states end at E0+W
  assign zero = wdec == '0;
  assign ext_ok = |(sel & EXT_MASK & ~DTACK_EXT_n);
  assign wd_inc = wd + TO_W'(1);
  assign term = mode == M_INT ? zero :
                mode == M_EXT ? zero && ext_ok :
                mode == M_VEC ? !DTACK_VEC_n : 1'b0;
  assign BUSY = state != S_IDLE;
  always_comb begin
    wfield = '0;
    for (int i = 0; i < NUM_CS; i++)
      if (cs[i]) wfield = WAIT_STATES[i*WAIT_W +: WAIT_W];
  end
  always_comb begin
    nxt = state;
    mode_n = mode;
    sel_n = sel;
    wcnt_n = wcnt;
    wd_n = wd;
    if (state == S_IDLE) begin
      if (!AS_n) begin
        wd_n = '0;
        sel_n = cs;
        wcnt_n = '0;
        if (FC == 3'b111) begin
          mode_n = M_VEC;
          nxt = AV[ADDR_L] ? S_VPA : S_WAIT;
        end else if (multi) begin
          mode_n = M_NONE;
          nxt = S_BERR;
        end else if (|cs) begin
          wcnt_n = wfield;
          mode_n = is_ext ? M_EXT : M_INT;
          nxt = (wfield == '0 && !is_ext) ? S_ACK : S_WAIT;
        end else begin
          mode_n = M_NONE;
          nxt = S_WAIT;
        end
      end
    end else if (state == S_WAIT) begin
      wcnt_n = wdec;
      wd_n = wd_inc;
      nxt = AS_n ? S_IDLE : term ? S_ACK : wd_inc == TO ? S_BERR : S_WAIT;
    end else if (AS_n) begin
      nxt = S_IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IDLE;
      mode <= M_NONE;
      sel <= '0;
      wcnt <= '0;
      wd <= '0;
      DTACK_n <= 1'b1;
      VPA_n <= 1'b1;
      BERR_n <= 1'b1;
      BERR_CNT <= '0;
    end else begin
      state <= nxt;
      mode <= mode_n;
      sel <= sel_n;
      wcnt <= wcnt_n;
      wd <= wd_n;
      DTACK_n <= nxt != S_ACK;
      VPA_n <= nxt != S_VPA;
      BERR_n <= nxt != S_BERR;
      BERR_CNT <= CNT_CLR ? '0 :
                  (nxt == S_BERR && state != S_BERR && BERR_CNT != 8'hFF) ? BERR_CNT + 8'd1 : BERR_CNT;
    end
  end
endmodule

// File: tb/tb_bus_cycle_controller.sv
// tb_bus_cycle_controller: directed bus cycles with a scoreboard; a monitor checks
// termination kind, edge of assertion, BERR_CNT and release against queued expectations.
module tb_bus_cycle_controller;
  localparam int K_ACK = 0, K_VPA = 1, K_BERR = 2;
  typedef struct { int kind; int cyc; int cnt; } exp_t;
  logic CLK = 0, RST_n = 0, AS_n = 1, DTACK_VEC_n = 1, CNT_CLR = 0;
  logic [2:0] FC = 0, ADDR_L = 0;
  logic [3:0] CS_n = 4'hF, DTACK_EXT_n = 4'hF;
  logic DTACK_n, VPA_n, BERR_n, BUSY;
  logic [7:0] BERR_CNT;
  int checks = 0, errors = 0, cyc = 0, exp_cnt = 0, k;
  logic as_q = 1;
  logic [2:0] prev = 3'b111, t;
  exp_t q[$];
  exp_t e;

  bus_cycle_controller #(
    .NUM_CS(4), .WAIT_W(4), .WAIT_STATES(16'h0320), .EXT_MASK(4'b1000),
    .AUTOVEC_MASK(7'h6F), .TO_W(8), .BERR_TIMEOUT(64)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .AS_n(AS_n), .FC(FC), .ADDR_L(ADDR_L), .CS_n(CS_n),
    .DTACK_EXT_n(DTACK_EXT_n), .DTACK_VEC_n(DTACK_VEC_n), .CNT_CLR(CNT_CLR),
    .DTACK_n(DTACK_n), .VPA_n(VPA_n), .BERR_n(BERR_n), .BUSY(BUSY), .BERR_CNT(BERR_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    as_q <= AS_n;
  end

  task automatic chk(input string n, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, want);
    end
  endtask

  always @(negedge CLK) begin
    t = {BERR_n, VPA_n, DTACK_n};
    if (!RST_n) prev = 3'b111;
    else begin
      if ($countones(~t) > 1) begin
        errors++;
        $display("FAIL onehot got %b want at most one low", t);
      end
      if (prev == 3'b111 && t != 3'b111) begin
        k = !DTACK_n ? K_ACK : !VPA_n ? K_VPA : K_BERR;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected termination got kind %0d want none", k);
        end else begin
          e = q.pop_front();
          chk("kind", k, e.kind);
          chk("edge", cyc, e.cyc);
          chk("berr_cnt", int'(BERR_CNT), e.cnt);
        end
      end
      if (prev != 3'b111 && as_q) chk("release", int'(t), 3'b111);
      prev = t;
    end
  end

  task automatic idle_inputs();
    AS_n = 1; CS_n = 4'hF; DTACK_EXT_n = 4'hF; DTACK_VEC_n = 1; FC = 0; ADDR_L = 0;
  endtask

  // ext_d/vec_d: terminator goes low so it is first sampled at edge E0+d (0 = never)
  task automatic run(input logic [3:0] cs, input logic [2:0] fc, input logic [2:0] al,
                     input int kind, input int lat, input int ext_d, input int vec_d);
    int e0;
    bit done;
    CS_n = cs; FC = fc; ADDR_L = al; AS_n = 0;
    e0 = cyc + 1;
    if (kind == K_BERR && exp_cnt < 255) exp_cnt++;
    q.push_back('{kind, e0 + lat, exp_cnt});
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK); #1;
      if (ext_d > 0 && cyc - e0 == ext_d - 1) DTACK_EXT_n[3] = 0;
      if (vec_d > 0 && cyc - e0 == vec_d - 1) DTACK_VEC_n = 0;
      done = !(DTACK_n && VPA_n && BERR_n);
    end
    if (!done) begin
      errors++;
      $display("FAIL cycle_timeout got no termination want kind %0d", kind);
    end
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dtack", DTACK_n, 1);
    chk("rst_vpa", VPA_n, 1);
    chk("rst_berr", BERR_n, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_cnt", int'(BERR_CNT), 0);
    RST_n = 1;
    @(posedge CLK); #1;
    run(4'b1101, 3'd5, 0, K_ACK, 2, 0, 0);
    run(4'b1110, 3'd5, 0, K_ACK, 0, 0, 0);
    run(4'b1011, 3'd1, 0, K_ACK, 3, 0, 0);
    run(4'b0111, 3'd5, 0, K_ACK, 5, 5, 0);
    run(4'b0111, 3'd5, 0, K_ACK, 1, 1, 0);
    run(4'b1111, 3'd7, 6, K_VPA, 0, 0, 0);
    run(4'b1111, 3'd7, 5, K_ACK, 4, 0, 4);
    run(4'b1111, 3'd7, 0, K_ACK, 2, 0, 2);
    run(4'b1100, 3'd5, 0, K_BERR, 0, 0, 0);
    run(4'b1111, 3'd5, 0, K_BERR, 64, 0, 0);
    // abort: AS_n released before ch2's three wait states elapse
    CS_n = 4'b1011; FC = 3'd5; AS_n = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_busy_in_wait", BUSY, 1);
    idle_inputs();
    @(posedge CLK); #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_outs", int'({BERR_n, VPA_n, DTACK_n}), 3'b111);
    chk("abort_cnt", int'(BERR_CNT), exp_cnt);
    run(4'b1101, 3'd5, 0, K_ACK, 2, 0, 0);
    for (int i = 0; i < 300; i++) run(4'b1111, 3'd5, 0, K_BERR, 64, 0, 0);
    chk("sat_cnt", int'(BERR_CNT), 255);
    CNT_CLR = 1;
    @(posedge CLK); #1;
    CNT_CLR = 0;
    exp_cnt = 0;
    chk("clr_cnt", int'(BERR_CNT), 0);
    run(4'b1100, 3'd5, 0, K_BERR, 0, 0, 0);
    // asynchronous reset in the middle of a watchdog wait
    AS_n = 0;
    repeat (5) @(posedge CLK);
    #3;
    RST_n = 0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_outs", int'({BERR_n, VPA_n, DTACK_n}), 3'b111);
    chk("arst_cnt", int'(BERR_CNT), 0);
    exp_cnt = 0;
    idle_inputs();
    @(posedge CLK); #1;
    RST_n = 1;
    @(posedge CLK); #1;
    run(4'b1101, 3'd5, 0, K_ACK, 2, 0, 0);
    repeat (3) @(posedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
